// File: rtl/irrigation_sequencer.sv
// Irrigation sequencer: tick prescaler, sensor stability filter and
// valve-control FSM for sprinkler/drip runs with cooldown and tank fault.
module irrigation_sequencer #(
   parameter int TICK_DIV       = 1000,
   parameter int STABLE_TICKS   = 4,
   parameter int SPRINKLE_TICKS = 30,
   parameter int DRIP_TICKS     = 60,
   parameter int COOLDOWN_TICKS = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       air_umidity,
   input  logic       soil_umidity,
   input  logic       temperature,
   input  logic [1:0] water_box,
   output logic       sprinkler,
   output logic       drip,
   output logic       busy,
   output logic       fault,
   output logic [2:0] state
);

   localparam int PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int SW   = $clog2(STABLE_TICKS + 1);
   localparam int RMX1 = (SPRINKLE_TICKS > DRIP_TICKS) ? SPRINKLE_TICKS : DRIP_TICKS;
   localparam int RMAX = (RMX1 > COOLDOWN_TICKS) ? RMX1 : COOLDOWN_TICKS;
   localparam int RW   = $clog2(RMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SAMPLE   = 3'd1,
      S_SPRINKLE = 3'd2,
      S_DRIP     = 3'd3,
      S_COOLDOWN = 3'd4,
      S_FAULT    = 3'd5
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [PW-1:0]   r_pre;
   logic [4:0]      r_prev;
   logic [SW-1:0]   r_scnt;
   logic [RW-1:0]   r_run;
   logic            r_spr;
   logic            r_drip;
   logic            r_busy;
   logic            r_fault;
   logic            w_tick;
   logic [4:0]      w_vec;
   logic            w_change;
   logic            w_stable;
   logic            w_entry;
   logic            w_empty;
   logic            w_spr_req;
   logic            w_drip_req;

   assign w_tick   = (r_pre == PW'(TICK_DIV - 1));
   assign w_vec    = {air_umidity, soil_umidity, temperature, water_box};
   assign w_change = (w_vec != r_prev);
   // A change seen this cycle vetoes a decision even if the count is full.
   assign w_stable = (r_scnt == SW'(STABLE_TICKS)) && !w_change;
   assign w_entry  = (w_next != r_state);
   assign w_empty  = (water_box == 2'b00);

   assign w_spr_req = !soil_umidity &
                      (!air_umidity |
                       (air_umidity & !temperature & water_box[1]));
   assign w_drip_req = !soil_umidity & air_umidity &
                       (temperature | (!temperature & (water_box == 2'b01)));

   assign sprinkler = r_spr;
   assign drip      = r_drip;
   assign busy      = r_busy;
   assign fault     = r_fault;
   assign state     = r_state;

   // Free-running tick prescaler.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pre <= '0;
      end else if (w_tick) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + 1'b1;
      end
   end

   // Stability filter: restart on input change or state entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev <= '0;
         r_scnt <= '0;
      end else begin
         r_prev <= w_vec;
         if (w_change || w_entry) begin
            r_scnt <= '0;
         end else if (w_tick && (r_scnt != SW'(STABLE_TICKS))) begin
            r_scnt <= r_scnt + 1'b1;
         end
      end
   end

   // Run/cooldown counter: load on entry, count down on ticks.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_run <= '0;
      end else if (w_entry) begin
         case (w_next)
            S_SPRINKLE: r_run <= RW'(SPRINKLE_TICKS);
            S_DRIP:     r_run <= RW'(DRIP_TICKS);
            S_COOLDOWN: r_run <= RW'(COOLDOWN_TICKS);
            default:    r_run <= '0;
         endcase
      end else if (w_tick && (r_run != '0)) begin
         r_run <= r_run - 1'b1;
      end
   end

   // State register and registered valve/status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_spr   <= 1'b0;
         r_drip  <= 1'b0;
         r_busy  <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_next;
         r_spr   <= (w_next == S_SPRINKLE);
         r_drip  <= (w_next == S_DRIP);
         r_busy  <= (w_next == S_SPRINKLE) || (w_next == S_DRIP) ||
                    (w_next == S_COOLDOWN);
         r_fault <= (w_next == S_FAULT);
      end
   end

   // Next-state decision.
   always_comb begin
      w_next = r_state;
      if (!enable && (r_state != S_FAULT)) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_next = S_SAMPLE;
            end
            S_SAMPLE: begin
               if (w_stable) begin
                  if (w_empty)         w_next = S_FAULT;
                  else if (w_spr_req)  w_next = S_SPRINKLE;
                  else if (w_drip_req) w_next = S_DRIP;
               end
            end
            S_SPRINKLE, S_DRIP: begin
               if (w_empty)           w_next = S_FAULT;
               else if (soil_umidity) w_next = S_COOLDOWN;
               else if (r_run == '0)  w_next = S_COOLDOWN;
            end
            S_COOLDOWN: begin
               if (r_run == '0) w_next = S_SAMPLE;
            end
            S_FAULT: begin
               if (!w_empty && w_stable) w_next = S_SAMPLE;
            end
            default: begin
               w_next = S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed testbench for irrigation_sequencer with small timing
// parameters; run lengths are checked against the prescaler phase window.
module tb_irrigation_sequencer;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       air_umidity;
   logic       soil_umidity;
   logic       temperature;
   logic [1:0] water_box;
   logic       sprinkler;
   logic       drip;
   logic       busy;
   logic       fault;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   irrigation_sequencer #(
      .TICK_DIV       (4),
      .STABLE_TICKS   (2),
      .SPRINKLE_TICKS (3),
      .DRIP_TICKS     (5),
      .COOLDOWN_TICKS (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .air_umidity  (air_umidity),
      .soil_umidity (soil_umidity),
      .temperature  (temperature),
      .water_box    (water_box),
      .sprinkler    (sprinkler),
      .drip         (drip),
      .busy         (busy),
      .fault        (fault),
      .state        (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_in(input logic a, input logic s, input logic t,
                         input logic [1:0] b);
      air_umidity  = a;
      soil_umidity = s;
      temperature  = t;
      water_box    = b;
   endtask

   task automatic wait_state(input logic [2:0] s, input int lim,
                             output bit ok);
      int n;
      n = 0;
      while (state !== s && n < lim) begin
         @(negedge clk);
         n++;
      end
      ok = (state === s);
   endtask

   task automatic count_state(input logic [2:0] s, output int n);
      n = 0;
      while (state === s && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset  = 1'b1;
      enable = 1'b0;
      set_in(0, 0, 0, 2'b00);
      repeat (3) @(negedge clk);
      checks++;
      if (state !== 3'd0) begin
         errors++; $display("FAIL rst_state: got %0d want 0", state);
      end
      checks++;
      if ({sprinkler, drip, busy, fault} !== 4'b0000) begin
         errors++;
         $display("FAIL rst_outs: got %b want 0000",
                  {sprinkler, drip, busy, fault});
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (state !== 3'd0) begin
         errors++; $display("FAIL rst_idle_dis: got %0d want 0", state);
      end
   endtask

   task automatic test_sprinkle;
      bit ok;
      int n;
      set_in(0, 0, 0, 2'b11);
      enable = 1'b1;
      @(negedge clk);
      checks++;
      if (state !== 3'd1) begin
         errors++; $display("FAIL spr_sample: got %0d want 1", state);
      end
      wait_state(3'd2, 40, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL spr_enter: got %0d want 2", state);
      end
      checks++;
      if ({sprinkler, drip, busy} !== 3'b101) begin
         errors++;
         $display("FAIL spr_outs: got %b want 101", {sprinkler, drip, busy});
      end
      count_state(3'd2, n);
      checks++;
      if (n < 10 || n > 13) begin
         errors++; $display("FAIL spr_len: got %0d want 10..13", n);
      end
      checks++;
      if ({state, sprinkler, busy} !== {3'd4, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL spr_cool: got st=%0d spr=%b busy=%b want 4 0 1",
                  state, sprinkler, busy);
      end
      count_state(3'd4, n);
      checks++;
      if (n < 6 || n > 9) begin
         errors++; $display("FAIL cool_len: got %0d want 6..9", n);
      end
      checks++;
      if ({state, busy} !== {3'd1, 1'b0}) begin
         errors++;
         $display("FAIL cool_exit: got st=%0d busy=%b want 1 0", state, busy);
      end
   endtask

   task automatic test_drip;
      bit ok;
      bit spr_seen;
      bit drip_lo;
      int n;
      enable = 1'b0;
      @(negedge clk);
      checks++;
      if (state !== 3'd0) begin
         errors++; $display("FAIL drip_idle: got %0d want 0", state);
      end
      set_in(1, 0, 1, 2'b10);
      enable = 1'b1;
      wait_state(3'd3, 40, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL drip_enter: got %0d want 3", state);
      end
      n = 0;
      spr_seen = 1'b0;
      drip_lo  = 1'b0;
      while (state === 3'd3 && n < 200) begin
         if (sprinkler !== 1'b0) spr_seen = 1'b1;
         if (drip !== 1'b1) drip_lo = 1'b1;
         n++;
         @(negedge clk);
      end
      checks++;
      if (n < 18 || n > 21) begin
         errors++; $display("FAIL drip_len: got %0d want 18..21", n);
      end
      checks++;
      if (spr_seen !== 1'b0) begin
         errors++; $display("FAIL drip_spr: got %b want 0", spr_seen);
      end
      checks++;
      if (drip_lo !== 1'b0) begin
         errors++; $display("FAIL drip_hold: got %b want 0", drip_lo);
      end
      checks++;
      if ({state, drip} !== {3'd4, 1'b0}) begin
         errors++;
         $display("FAIL drip_cool: got st=%0d drip=%b want 4 0", state, drip);
      end
   endtask

   task automatic test_soil_abort;
      bit ok;
      enable = 1'b0;
      @(negedge clk);
      set_in(0, 0, 0, 2'b11);
      enable = 1'b1;
      wait_state(3'd2, 40, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL abort_enter: got %0d want 2", state);
      end
      repeat (2) @(negedge clk);
      soil_umidity = 1'b1;
      @(negedge clk);
      checks++;
      if ({state, sprinkler} !== {3'd4, 1'b0}) begin
         errors++;
         $display("FAIL abort: got st=%0d spr=%b want 4 0", state, sprinkler);
      end
   endtask

   task automatic test_fault;
      bit ok;
      int n;
      enable = 1'b0;
      @(negedge clk);
      set_in(1, 0, 1, 2'b10);
      enable = 1'b1;
      wait_state(3'd3, 40, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL flt_drip: got %0d want 3", state);
      end
      repeat (2) @(negedge clk);
      water_box = 2'b00;
      @(negedge clk);
      checks++;
      if ({state, fault, drip, busy} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL flt_enter: got st=%0d f=%b d=%b b=%b want 5 1 0 0",
                  state, fault, drip, busy);
      end
      enable = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (state !== 3'd5) begin
         errors++; $display("FAIL flt_en_ign: got %0d want 5", state);
      end
      enable    = 1'b1;
      water_box = 2'b01;
      count_state(3'd5, n);
      checks++;
      if (n < 7 || n > 10) begin
         errors++; $display("FAIL flt_hold: got %0d want 7..10", n);
      end
      checks++;
      if ({state, fault} !== {3'd1, 1'b0}) begin
         errors++;
         $display("FAIL flt_exit: got st=%0d f=%b want 1 0", state, fault);
      end
   endtask

   task automatic test_toggle;
      bit left;
      enable = 1'b0;
      @(negedge clk);
      set_in(0, 0, 0, 2'b11);
      enable = 1'b1;
      @(negedge clk);
      checks++;
      if (state !== 3'd1) begin
         errors++; $display("FAIL tog_sample: got %0d want 1", state);
      end
      left = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (i % 3 == 2) temperature = ~temperature;
         @(negedge clk);
         if (state !== 3'd1) left = 1'b1;
      end
      checks++;
      if (left !== 1'b0) begin
         errors++; $display("FAIL tog_stay: got left=%b want 0", left);
      end
      enable = 1'b0;
      @(negedge clk);
      checks++;
      if (state !== 3'd0) begin
         errors++; $display("FAIL tog_dis: got %0d want 0", state);
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      set_in(0, 0, 0, 2'b11);
      enable = 1'b1;
      wait_state(3'd2, 40, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL rmid_enter: got %0d want 2", state);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (state !== 3'd0) begin
         errors++; $display("FAIL rmid_state: got %0d want 0", state);
      end
      checks++;
      if ({sprinkler, drip, busy, fault} !== 4'b0000) begin
         errors++;
         $display("FAIL rmid_outs: got %b want 0000",
                  {sprinkler, drip, busy, fault});
      end
      reset  = 1'b0;
      enable = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      set_in(0, 0, 0, 2'b00);
      @(negedge clk);
      test_reset();
      test_sprinkle();
      test_drip();
      test_soil_abort();
      test_fault();
      test_toggle();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
